// File: rtl/ntt_addr_seq.sv
// Butterfly address / twiddle-index sequencer for N-point NTT (Cooley-Tukey)
// and INTT (Gentleman-Sande) with backpressure, inter-stage bubbles and abort.
module ntt_addr_seq #(
  parameter int unsigned LOG_N       = 8,
  parameter int unsigned MIN_LEN_LOG = 1,
  parameter int unsigned STAGE_GAP   = 0
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         i_start,
  input  logic                                         i_sel,
  input  logic                                         i_abort,
  input  logic                                         i_ready,
  output logic                                         o_valid,
  output logic [LOG_N-1:0]                             o_addr_up,
  output logic [LOG_N-1:0]                             o_addr_dn,
  output logic [LOG_N-MIN_LEN_LOG-1:0]                 o_zeta_idx,
  output logic                                         o_sel,
  output logic [$clog2(LOG_N-MIN_LEN_LOG+1)-1:0]       o_stage,
  output logic                                         o_stage_last,
  output logic                                         o_done,
  output logic                                         o_busy
);

  localparam int unsigned NSTAGES = LOG_N - MIN_LEN_LOG;
  localparam int unsigned AW      = LOG_N;
  localparam int unsigned ZW      = NSTAGES;
  localparam int unsigned SW      = $clog2(NSTAGES + 1);
  localparam int unsigned BW      = LOG_N - 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;

  state_t          state;
  logic            start_q;
  logic            armed;
  logic [BW-1:0]   beat;
  logic [3:0]      gap_cnt;

  logic            start_edge;
  logic            xfer;
  logic            load;
  logic            ld_sel;
  logic [SW-1:0]   ld_stage;
  logic [BW-1:0]   ld_beat;
  int unsigned     span;
  logic [AW-1:0]   blk;
  logic [AW-1:0]   nx_up;
  logic [AW-1:0]   nx_dn;
  logic [ZW-1:0]   nx_zeta;
  logic            nx_last;
  logic            nx_done;

  // armed blocks a level already high out of reset from counting as an edge
  assign start_edge = i_start & ~start_q & armed;
  assign xfer       = o_valid & i_ready;

  // Which beat gets presented next, if a load happens this cycle
  always_comb begin
    ld_sel   = o_sel;
    ld_stage = '0;
    ld_beat  = '0;
    if (state == S_IDLE) begin
      ld_sel = i_sel;
    end else if (state == S_RUN && !o_stage_last) begin
      ld_stage = o_stage;
      ld_beat  = beat + BW'(1);
    end else begin
      ld_stage = o_stage + SW'(1);
    end
  end

  // Beat index -> (up, dn, zeta): span is log2 of the butterfly half-length
  always_comb begin
    span    = ld_sel ? (MIN_LEN_LOG + 32'(ld_stage)) : (LOG_N - 1 - 32'(ld_stage));
    blk     = AW'(ld_beat) >> span;
    nx_up   = (blk << (span + 1)) | (AW'(ld_beat) & ((AW'(1) << span) - AW'(1)));
    nx_dn   = nx_up | (AW'(1) << span);
    nx_zeta = ld_sel ? ((ZW'(1) << (NSTAGES - 32'(ld_stage))) - ZW'(1) - ZW'(blk))
                     : ((ZW'(1) << ld_stage) + ZW'(blk));
    nx_last = &ld_beat;
    nx_done = nx_last && (ld_stage == SW'(NSTAGES - 1));
  end

  always_comb begin
    load = 1'b0;
    if (!i_abort) begin
      unique case (state)
        S_IDLE:  load = start_edge;
        S_RUN:   load = xfer && !o_done && !(o_stage_last && (STAGE_GAP != 0));
        S_GAP:   load = (gap_cnt == '0);
        default: load = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      start_q      <= 1'b0;
      armed        <= 1'b0;
      beat         <= '0;
      gap_cnt      <= '0;
      o_valid      <= 1'b0;
      o_addr_up    <= '0;
      o_addr_dn    <= '0;
      o_zeta_idx   <= '0;
      o_sel        <= 1'b0;
      o_stage      <= '0;
      o_stage_last <= 1'b0;
      o_done       <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      start_q <= i_start;
      armed   <= 1'b1;
      if (i_abort) begin
        state        <= S_IDLE;
        o_valid      <= 1'b0;
        o_busy       <= 1'b0;
        o_done       <= 1'b0;
        o_stage_last <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (start_edge) state <= S_RUN;
          S_RUN: begin
            if (xfer && o_done) begin
              state        <= S_IDLE;
              o_valid      <= 1'b0;
              o_busy       <= 1'b0;
              o_done       <= 1'b0;
              o_stage_last <= 1'b0;
            end else if (xfer && o_stage_last && (STAGE_GAP != 0)) begin
              state        <= S_GAP;
              gap_cnt      <= 4'(STAGE_GAP - 1);
              o_valid      <= 1'b0;
              o_stage_last <= 1'b0;
            end
          end
          S_GAP: begin
            if (gap_cnt == '0) state <= S_RUN;
            else               gap_cnt <= gap_cnt - 4'd1;
          end
          default: state <= S_IDLE;
        endcase
        if (load) begin
          o_valid      <= 1'b1;
          o_busy       <= 1'b1;
          o_sel        <= ld_sel;
          o_stage      <= ld_stage;
          beat         <= ld_beat;
          o_addr_up    <= nx_up;
          o_addr_dn    <= nx_dn;
          o_zeta_idx   <= nx_zeta;
          o_stage_last <= nx_last;
          o_done       <= nx_done;
        end
      end
    end
  end

endmodule

// File: doc/ntt_addr_seq.md
Name: ntt_addr_seq

Overview:
Parametrised butterfly address/twiddle sequencer for the NTT/INTT datapath. It generates the full (up, dn, zeta) beat stream for an N-point transform. Mode is selected per transform: Cooley-Tukey forward or Gentleman-Sande inverse. Compared with the fixed 256-point generator it adds:
- generic N and minimum butterfly span
- valid/ready backpressure
- programmable inter-stage bubbles for RAW hazards
- a stage index output
- synchronous abort

It sits between the transform controller and the coefficient RAM/butterfly unit.

Parameters:
LOG_N, 8, log2 of transform size N. Address width = LOG_N.
MIN_LEN_LOG, 1, log2 of the smallest butterfly span. NSTAGES = LOG_N - MIN_LEN_LOG. Zeta width ZW = NSTAGES.
STAGE_GAP, 0, idle cycles (o_valid low) inserted after each non-final stage, range 0..15.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_start  in  1  level start; a rising edge while idle launches a transform
i_sel  in  1  0 = NTT, 1 = INTT; sampled on the launching edge
i_abort  in  1  synchronous abort
i_ready  in  1  downstream accepts the current beat
o_valid  out  1  beat valid
o_addr_up  out  LOG_N  upper operand address
o_addr_dn  out  LOG_N  lower operand address
o_zeta_idx  out  ZW  twiddle index
o_sel  out  1  mode latched for the current transform
o_stage  out  ceil(log2(NSTAGES+1))  stage index 0..NSTAGES-1
o_stage_last  out  1  current beat is the final beat of its stage
o_done  out  1  current beat is the final beat of the transform
o_busy  out  1  transform in progress, including gaps

Behaviour:
Reset:
- rst_n low clears all outputs and all state asynchronously, including the registered copy of i_start.
- Every output is 0 while reset is held.

Start:
- A rising edge is detected as i_start=1 in cycle c and i_start=0 in cycle c-1.
- If idle, beat 0 is presented with o_valid=1 and o_busy=1 from cycle c+1. i_sel is latched into o_sel.
- A rising edge while busy is ignored and not queued.

Handshake:
- A beat transfers when o_valid & i_ready.
- While o_valid & !i_ready, all o_* are held stable.
- o_valid never drops without a transfer, except on abort.

Sequence, NTT (i_sel=0):
- Counter k starts at 1. len runs N/2 down to 2^MIN_LEN_LOG, halving each stage.
- For each block start in 0, 2·len, 4·len, …: zeta = k, then k increments.
- For each j in start..start+len-1: up = j, dn = j+len.

Sequence, INTT (i_sel=1):
- Counter k starts at 2^NSTAGES - 1. len runs 2^MIN_LEN_LOG up to N/2, doubling each stage.
- Block and j ordering are the same as NTT; k decrements per block.

Counts and flags:
- Each stage has N/2 beats; the transform has NSTAGES·N/2 beats.
- o_stage_last=1 on beat N/2-1 of each stage.
- o_done=1 only on the final beat. It coincides with o_stage_last.

Stage gap:
- After the stage_last beat of a non-final stage transfers, o_valid=0 for exactly STAGE_GAP cycles, with o_busy held at 1.
- The next stage's first beat follows. With STAGE_GAP=0 there is no bubble.

Completion:
- The cycle after the done beat transfers, o_valid=0 and o_busy=0. The block is ready for a new edge.
- An edge in that same cycle launches immediately.

Abort:
- i_abort=1 in any cycle forces o_valid=0, o_busy=0, o_done=0 next cycle.
- Abort wins over a simultaneous start edge and over a simultaneous transfer; no done is emitted.

FSM:
- IDLE →(edge) RUN
- RUN →(stage_last xfer, non-final, GAP>0) GAP; RUN →(stage_last xfer, non-final, GAP=0) stays RUN
- GAP →(gap count exhausted) RUN
- RUN →(done xfer) IDLE
- any state →(abort) IDLE

Widths and idle values:
- All counters are unsigned. The k range fits ZW bits exactly (NTT k ends at 2^NSTAGES-1, INTT k ends at 1); no wrap is allowed.
- Address outputs retain their last value when idle. Flags are 0 when idle.

Test Plan:
1. Defaults (LOG_N=8, MIN_LEN_LOG=1, GAP=0), NTT, i_ready=1 → first beats (0,128,z1), (1,129,z1); stage 0 ends at (127,255,z1). Stage 1 begins (0,64,z2). Last beat (253,255,z127) with o_done=1, o_stage=6. 896 beats total in 896 consecutive cycles.
2. Defaults, INTT → first beats (0,2,z127), (1,3,z127), (4,6,z126). Final beat (127,255,z1) with o_done=1. o_sel=1 throughout.
3. Backpressure: drop i_ready for 5 cycles at beat 10 → beat 10 held bit-stable for all 5 cycles. No beat is skipped or duplicated; total 896 transfers.
4. STAGE_GAP=3, NTT → exactly 3 cycles of o_valid=0 with o_busy=1 after each of stages 0..5. No gap after stage 6. Total busy cycles 896+18.
5. i_abort asserted at beat 300 → next cycle o_valid=0, o_busy=0, o_done never seen. A subsequent start edge restarts at (0,128,z1). A start edge pulsed mid-run (no abort) has no effect.
6. Reset: rst_n low mid-transform → all outputs 0 immediately. After release, holding i_start high (no new edge) launches nothing.
